accu_sat_packer: RTL and testbench
==================================

// Module: accu_sat_packer
// PURPOSE
//  AXI-Stream stage directly downstream of the Accumulator, ahead of the DMA S2MM channel.
//  Each 64-bit signed result is arithmetic-right-shifted, saturated to 32 bits, and packed two per 64-bit beat.
//  Frames stay aligned to the input TLAST. A pulse reports when a frame has been fully drained.
// PARAMETERS
//  SHIFT   0   arithmetic right shift applied to each 64-bit sample before saturation (0..31)
// PORTS
//  sys_clk         in   1   single clock for all logic
//  sys_rst         in   1   asynchronous, active-high reset
//  pack_en         in   1   enable; while low, s_axis_tready=0 (no new input accepted)
//  pack_done       out  1   one-cycle pulse when an output beat with TLAST completes its handshake
//  s_axis_tvalid   in   1   input sample valid
//  s_axis_tready   out  1   input ready
//  s_axis_tdata    in   64  signed accumulator result
//  s_axis_tkeep    in   8   ignored (accumulator always drives 8'hFF)
//  s_axis_tlast    in   1   last sample of frame
//  m_axis_tvalid   out  1   output beat valid
//  m_axis_tready   in   1   output ready
//  m_axis_tdata    out  64  [31:0]=first sample of pair, [63:32]=second sample
//  m_axis_tkeep    out  8   8'hFF full pair; 8'h0F when only lane 0 is valid
//  m_axis_tlast    out  1   last beat of frame
// BEHAVIOUR
//  Reset (async, immediate): all outputs 0; FSM=EMPTY; lane-0 holding register cleared.
//  Reset also discards any pending beat or half pair.
//  Sample path: v = s_axis_tdata >>> SHIFT.
//   v > 2^31-1  -> 32'h7FFF_FFFF
//   v < -2^31   -> 32'h8000_0000
//   otherwise   -> v[31:0]
//  Output register: single stage holding m_* fields.
//   Loaded only when empty or when the current beat handshakes in the same cycle.
//   m_axis_tdata, m_axis_tkeep and m_axis_tlast stay stable while tvalid=1 and tready=0.
//  s_axis_tready = pack_en && (!m_axis_tvalid || m_axis_tready). This is a combinational function of registered state and inputs.
//  FSM (handshake = s_axis_tvalid && s_axis_tready):
//   EMPTY, handshake, tlast=0 -> store sat value in lane0; go to HALF.
//   EMPTY, handshake, tlast=1 -> load output {32'h0, sat}, tkeep=8'h0F, tlast=1; stay EMPTY.
//   HALF, handshake -> load output {sat, lane0}, tkeep=8'hFF, tlast=s_axis_tlast; go to EMPTY.
//   No handshake -> state held. A HALF sample is retained indefinitely, including across pack_en low.
//  Latency: the output beat is valid the cycle after the input handshake that completes it.
//  Throughput: with m_axis_tready=1, one input per cycle and one output every two inputs.
//  m_axis_tvalid clears after a handshake unless a new beat loads in the same cycle.
//  pack_done = registered (m_axis_tvalid && m_axis_tready && m_axis_tlast); 1-cycle pulse the cycle after.
//  Input TLAST with no TLAST asserted mid-frame: a frame of N samples yields ceil(N/2) beats.
//  When N is odd, the final beat has tkeep=8'h0F and upper lane 32'h0.
// CONFIGURATION
//  ACCU_PACK_SATCNT_EN defined: adds two outputs.
//   sat_cnt  out 16: saturating counter of clipped samples. Cleared on reset and on the pack_done pulse cycle.
//   sat_flag out 1: sticky flag, high once any sample in the current frame clipped. Cleared with sat_cnt.
//   A clipped sample accepted in the same cycle as pack_done counts toward the new frame (count = 1).
//  ACCU_PACK_SATCNT_EN undefined: ports absent; no counter logic.
// TESTING
//  1. pack_en=1, tready=1; frame of 10 samples 10,0,-10..-80, tlast on the 10th
//     -> 5 beats, {0,10},{-20,-10},..,{-80,-70}; all tkeep FF; tlast on beat 5; pack_done pulses once.
//  2. Frame of 3 samples 1,2,3
//     -> beats {2,1} tkeep FF tlast 0, then {0,3} tkeep 0F tlast 1.
//  3. Samples 64'h1_0000_0000 and -2^40 (SHIFT=0)
//     -> beat {32'h8000_0000,32'h7FFF_FFFF}; with macro, sat_cnt=2 and sat_flag=1 until pack_done.
//  4. m_axis_tready low for 6 cycles while valid
//     -> s_axis_tready=0 throughout, m_* fields unchanged; no samples lost after release.
//  5. sys_rst pulsed while in HALF with a beat pending
//     -> outputs 0 immediately; a next 2-sample frame 5,6 yields {6,5} with no stale data.
//  6. SHIFT=4, sample 160 then -161 -> beat {-11,10} (arithmetic shift floors toward minus infinity).

Source files
------------

// File: rtl/accu_sat_packer_if.sv
// rtl/accu_sat_packer_if.sv - AXI-Stream bundle (tdata/tkeep/tlast with valid/ready) for accu_sat_packer
interface accu_sat_packer_if;
  logic        tvalid;
  logic        tready;
  logic [63:0] tdata;
  logic [7:0]  tkeep;
  logic        tlast;

  modport master (output tvalid, tdata, tkeep, tlast, input tready);
  modport slave  (input tvalid, tdata, tkeep, tlast, output tready);
endinterface

// File: rtl/accu_sat_packer.sv
// rtl/accu_sat_packer.sv - shift/saturate 64-bit samples to 32 bits and pack two per output beat
// Optional build macro ACCU_PACK_SATCNT_EN adds sat_cnt/sat_flag clip statistics.
module accu_sat_packer #(
  parameter int SHIFT = 0
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              pack_en,
  output logic              pack_done,
  accu_sat_packer_if.slave  s_axis,
  accu_sat_packer_if.master m_axis
`ifdef ACCU_PACK_SATCNT_EN
  ,
  output logic [15:0]       sat_cnt,
  output logic              sat_flag
`endif
);
  typedef enum logic {ST_EMPTY, ST_HALF} state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic [31:0]        r_lane0;
  logic               r_m_valid;
  logic [63:0]        r_m_data;
  logic [7:0]         r_m_keep;
  logic               r_m_last;
  logic               r_done;

  logic signed [63:0] w_shifted;
  logic               w_clip_hi;
  logic               w_clip_lo;
  logic [31:0]        w_sat;
  logic               w_s_ready;
  logic               w_in_hs;
  logic               w_out_hs;
  logic               w_load;
  logic               w_store_lane0;
  logic [63:0]        w_load_data;
  logic [7:0]         w_load_keep;
  logic               w_load_last;
  logic               w_unused_keep;

  assign w_unused_keep = ^s_axis.tkeep;

  assign w_shifted = $signed(s_axis.tdata) >>> SHIFT;
  assign w_clip_hi = w_shifted > 64'sh0000_0000_7FFF_FFFF;
  assign w_clip_lo = w_shifted < 64'shFFFF_FFFF_8000_0000;
  assign w_sat     = w_clip_hi ? 32'h7FFF_FFFF :
                     w_clip_lo ? 32'h8000_0000 : w_shifted[31:0];

  // Input may only advance when the single output slot is free or draining this cycle.
  assign w_s_ready = pack_en && (!r_m_valid || m_axis.tready);
  assign w_in_hs   = s_axis.tvalid && w_s_ready;
  assign w_out_hs  = r_m_valid && m_axis.tready;

  assign s_axis.tready = w_s_ready;
  assign m_axis.tvalid = r_m_valid;
  assign m_axis.tdata  = r_m_data;
  assign m_axis.tkeep  = r_m_keep;
  assign m_axis.tlast  = r_m_last;
  assign pack_done     = r_done;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state  = r_state;
    w_store_lane0 = 1'b0;
    w_load        = 1'b0;
    w_load_data   = '0;
    w_load_keep   = '0;
    w_load_last   = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (w_in_hs) begin
          if (s_axis.tlast) begin
            w_load      = 1'b1;
            w_load_data = {32'h0, w_sat};
            w_load_keep = 8'h0F;
            w_load_last = 1'b1;
          end else begin
            w_store_lane0 = 1'b1;
            w_next_state  = ST_HALF;
          end
        end
      end
      ST_HALF: begin
        if (w_in_hs) begin
          w_load       = 1'b1;
          w_load_data  = {w_sat, r_lane0};
          w_load_keep  = 8'hFF;
          w_load_last  = s_axis.tlast;
          w_next_state = ST_EMPTY;
        end
      end
      default: w_next_state = ST_EMPTY;
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_lane0   <= '0;
      r_m_valid <= 1'b0;
      r_m_data  <= '0;
      r_m_keep  <= '0;
      r_m_last  <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      if (w_store_lane0) begin
        r_lane0 <= w_sat;
      end
      if (w_load) begin
        r_m_valid <= 1'b1;
        r_m_data  <= w_load_data;
        r_m_keep  <= w_load_keep;
        r_m_last  <= w_load_last;
      end else if (w_out_hs) begin
        r_m_valid <= 1'b0;
      end
      r_done <= w_out_hs && r_m_last;
    end
  end

`ifdef ACCU_PACK_SATCNT_EN
  logic        w_clip;
  logic [15:0] r_sat_cnt;
  logic        r_sat_flag;

  assign w_clip   = w_in_hs && (w_clip_hi || w_clip_lo);
  assign sat_cnt  = r_sat_cnt;
  assign sat_flag = r_sat_flag;

  // A clip landing on the pack_done cycle belongs to the next frame.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_sat_cnt  <= '0;
      r_sat_flag <= 1'b0;
    end else if (r_done) begin
      r_sat_cnt  <= {15'd0, w_clip};
      r_sat_flag <= w_clip;
    end else if (w_clip) begin
      if (r_sat_cnt != 16'hFFFF) begin
        r_sat_cnt <= r_sat_cnt + 16'd1;
      end
      r_sat_flag <= 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_accu_sat_packer.sv
// tb/tb_accu_sat_packer.sv - randomized self-checking bench for accu_sat_packer (SHIFT=0 and SHIFT=4 instances)
module tb_accu_sat_packer;
  typedef struct {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
  } beat_t;

  logic   sys_clk = 1'b0;
  logic   sys_rst = 1'b1;
  logic   pack_en = 1'b0;
  logic   pack_done0;
  logic   pack_done4;
  logic   drv_valid = 1'b0;
  longint drv_data = 0;
  logic   drv_last = 1'b0;
  logic   drv_mready = 1'b0;
  bit     rand_mode = 1'b0;

  int     n_checks = 0;
  int     n_pass = 0;
  int     done_cnt0 = 0;
  logic   done_exp0 = 1'b0;
  logic   done_exp4 = 1'b0;
  logic [63:0] last_beat0 = '0;
  logic [63:0] last_beat4 = '0;
  beat_t  exp0[$];
  beat_t  exp4[$];
  longint frame_q[$];

`ifdef ACCU_PACK_SATCNT_EN
  logic [15:0] sat_cnt0, sat_cnt4;
  logic        sat_flag0, sat_flag4;
`endif

  accu_sat_packer_if s0();
  accu_sat_packer_if m0();
  accu_sat_packer_if s4();
  accu_sat_packer_if m4();

  assign s0.tvalid = drv_valid;
  assign s0.tdata  = drv_data;
  assign s0.tkeep  = 8'hFF;
  assign s0.tlast  = drv_last;
  assign m0.tready = drv_mready;
  assign s4.tvalid = drv_valid;
  assign s4.tdata  = drv_data;
  assign s4.tkeep  = 8'hFF;
  assign s4.tlast  = drv_last;
  assign m4.tready = drv_mready;

  accu_sat_packer #(.SHIFT(0)) u_dut0 (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .pack_en   (pack_en),
    .pack_done (pack_done0),
    .s_axis    (s0.slave),
    .m_axis    (m0.master)
`ifdef ACCU_PACK_SATCNT_EN
    ,
    .sat_cnt   (sat_cnt0),
    .sat_flag  (sat_flag0)
`endif
  );

  accu_sat_packer #(.SHIFT(4)) u_dut4 (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .pack_en   (pack_en),
    .pack_done (pack_done4),
    .s_axis    (s4.slave),
    .m_axis    (m4.master)
`ifdef ACCU_PACK_SATCNT_EN
    ,
    .sat_cnt   (sat_cnt4),
    .sat_flag  (sat_flag4)
`endif
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [31:0] sat_ref(input longint x, input int sh);
    longint v;
    v = x >>> sh;
    if (v > 64'sd2147483647) return 32'h7FFF_FFFF;
    if (v < -64'sd2147483648) return 32'h8000_0000;
    return v[31:0];
  endfunction

  task automatic push_frame();
    int n;
    beat_t b0, b4;
    n = frame_q.size();
    for (int i = 0; i < n; i += 2) begin
      if (i + 1 < n) begin
        b0.data = {sat_ref(frame_q[i+1], 0), sat_ref(frame_q[i], 0)};
        b4.data = {sat_ref(frame_q[i+1], 4), sat_ref(frame_q[i], 4)};
        b0.keep = 8'hFF;
        b0.last = (i + 2 == n);
      end else begin
        b0.data = {32'h0, sat_ref(frame_q[i], 0)};
        b4.data = {32'h0, sat_ref(frame_q[i], 4)};
        b0.keep = 8'h0F;
        b0.last = 1'b1;
      end
      b4.keep = b0.keep;
      b4.last = b0.last;
      exp0.push_back(b0);
      exp4.push_back(b4);
    end
  endtask

  task automatic send_sample(input longint d, input bit last, output bit ok);
    ok = 1'b0;
    drv_data  = d;
    drv_last  = last;
    drv_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge sys_clk);
      if (s0.tready) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge sys_clk);
    #1;
    drv_valid = 1'b0;
  endtask

  task automatic send_frame();
    bit ok;
    push_frame();
    for (int i = 0; i < frame_q.size(); i++) begin
      send_sample(frame_q[i], i == frame_q.size() - 1, ok);
      if (!ok) chk("send_timeout", 0, 1);
      if (rand_mode) begin
        repeat ($urandom_range(0, 2)) @(posedge sys_clk);
        #1;
      end
    end
  endtask

  task automatic wait_drain(input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(negedge sys_clk);
      if (exp0.size() == 0 && exp4.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    chk(tag, ok, 1);
    repeat (3) @(posedge sys_clk);
    #1;
  endtask

  task automatic reset_mid(input string tag);
    drv_valid = 1'b0;
    #2;
    sys_rst = 1'b1;
    #1;
    chk({tag, "_tvalid"}, m0.tvalid, 0);
    chk({tag, "_tdata"}, m0.tdata, 0);
    chk({tag, "_tkeep"}, m0.tkeep, 0);
    chk({tag, "_done"}, pack_done0, 0);
    exp0.delete();
    exp4.delete();
    @(posedge sys_clk);
    #1;
    sys_rst = 1'b0;
  endtask

  function automatic longint rnd_sample();
    longint base;
    case ($urandom_range(0, 3))
      0: return longint'($urandom_range(0, 2000)) - 1000;
      1: return {$urandom, $urandom};
      2: begin
        base = $urandom_range(0, 1) ? 64'sd2147483647 : -64'sd2147483648;
        if ($urandom_range(0, 1)) base = base * 16;
        return base + longint'($urandom_range(0, 40)) - 20;
      end
      default: return $urandom_range(0, 1) ? (64'sd1 <<< 40) : -(64'sd1 <<< 40);
    endcase
  endfunction

  always @(posedge sys_clk) begin
    #1;
    if (rand_mode) begin
      drv_mready = $urandom_range(0, 3) != 0;
      pack_en    = $urandom_range(0, 7) != 0;
    end
  end

  always @(negedge sys_clk) begin
    if (sys_rst) begin
      done_exp0 = 1'b0;
    end else begin
      chk("done0", pack_done0, done_exp0);
      if (pack_done0) done_cnt0++;
      done_exp0 = 1'b0;
      if (m0.tvalid) begin
        if (exp0.size() == 0) chk("beat0_extra", 1, 0);
        else begin
          chk("data0", m0.tdata, exp0[0].data);
          chk("keep0", m0.tkeep, exp0[0].keep);
          chk("last0", m0.tlast, exp0[0].last);
          if (m0.tready) begin
            done_exp0  = exp0[0].last;
            last_beat0 = m0.tdata;
            void'(exp0.pop_front());
          end
        end
      end
      if (!pack_en) chk("en_low_ready0", s0.tready, 0);
    end
  end

  always @(negedge sys_clk) begin
    if (sys_rst) begin
      done_exp4 = 1'b0;
    end else begin
      chk("done4", pack_done4, done_exp4);
      done_exp4 = 1'b0;
      if (m4.tvalid) begin
        if (exp4.size() == 0) chk("beat4_extra", 1, 0);
        else begin
          chk("data4", m4.tdata, exp4[0].data);
          chk("keep4", m4.tkeep, exp4[0].keep);
          chk("last4", m4.tlast, exp4[0].last);
          if (m4.tready) begin
            done_exp4  = exp4[0].last;
            last_beat4 = m4.tdata;
            void'(exp4.pop_front());
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  d0;
    bit  ok;
    #1;
    chk("rst_tvalid", m0.tvalid, 0);
    chk("rst_tdata", m0.tdata, 0);
    chk("rst_tlast", m0.tlast, 0);
    chk("rst_done", pack_done0, 0);
    repeat (2) @(posedge sys_clk);
    #1;
    sys_rst    = 1'b0;
    pack_en    = 1'b1;
    drv_mready = 1'b1;

    d0 = done_cnt0;
    frame_q.delete();
    for (int i = 0; i < 10; i++) frame_q.push_back(10 - 10 * i);
    send_frame();
    wait_drain("t1_drain");
    chk("t1_done_cnt", done_cnt0 - d0, 1);
    chk("t1_last_beat", last_beat0, 64'hFFFF_FFB0_FFFF_FFBA);

    frame_q = '{1, 2, 3};
    send_frame();
    wait_drain("t2_drain");
    chk("t2_last_beat", last_beat0, 64'h0000_0000_0000_0003);

    drv_mready = 1'b0;
    frame_q = '{64'sh1_0000_0000, -(64'sd1 <<< 40)};
    send_frame();
    @(negedge sys_clk);
`ifdef ACCU_PACK_SATCNT_EN
    chk("t3_sat_cnt0", sat_cnt0, 2);
    chk("t3_sat_flag0", sat_flag0, 1);
    chk("t3_sat_cnt4", sat_cnt4, 1);
`endif
    @(posedge sys_clk);
    #1;
    drv_mready = 1'b1;
    wait_drain("t3_drain");
    chk("t3_beat", last_beat0, 64'h8000_0000_7FFF_FFFF);
`ifdef ACCU_PACK_SATCNT_EN
    chk("t3_sat_clr", sat_cnt0, 0);
    chk("t3_flag_clr", sat_flag0, 0);
`endif

    drv_mready = 1'b0;
    frame_q = '{101, 102, 103, 104, 105, 106};
    fork
      send_frame();
      begin
        repeat (12) begin
          @(negedge sys_clk);
          if (m0.tvalid) chk("t4_stall_sready", s0.tready, 0);
        end
        @(posedge sys_clk);
        #1;
        drv_mready = 1'b1;
      end
    join
    wait_drain("t4_drain");
    chk("t4_last_beat", last_beat0, 64'h0000_006A_0000_0069);

    drv_mready = 1'b0;
    frame_q = '{1, 2, 3, 4};
    push_frame();
    send_sample(1, 1'b0, ok);
    send_sample(2, 1'b0, ok);
    drv_data  = 3;
    drv_valid = 1'b1;
    @(posedge sys_clk);
    #1;
    reset_mid("t5a_rst");
    drv_mready = 1'b1;
    send_sample(7, 1'b0, ok);
    reset_mid("t5b_rst");
    frame_q = '{5, 6};
    send_frame();
    wait_drain("t5_drain");
    chk("t5_beat", last_beat0, 64'h0000_0006_0000_0005);

    frame_q = '{160, -161};
    send_frame();
    wait_drain("t6_drain");
    chk("t6_beat4", last_beat4, 64'hFFFF_FFF5_0000_000A);

    rand_mode = 1'b1;
    for (int f = 0; f < 30; f++) begin
      frame_q.delete();
      repeat ($urandom_range(1, 9)) frame_q.push_back(rnd_sample());
      send_frame();
    end
    rand_mode = 1'b0;
    @(posedge sys_clk);
    #1;
    pack_en    = 1'b1;
    drv_mready = 1'b1;
    wait_drain("rand_drain");
    chk("final_q0", exp0.size(), 0);
    chk("final_q4", exp4.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
